// File: rtl/burst_requester_if.sv
// Handshake bundle between the burst requester and its neighbours.
//   Client side : in_valid / in_data / in_ready (three independent clients)
//   Arbiter side: r (request out), g (grant in)
//   Sink side   : out_valid / out_data / out_src / out_last / out_ready
// The master modport is the requester itself. The slave modport is everything
// around it: clients, arbiter and sink.
interface burst_requester_if #(
  parameter int unsigned DW = 8
);
  logic [2:0]      in_valid;
  logic [3*DW-1:0] in_data;
  logic [2:0]      in_ready;
  logic [2:0]      r;
  logic [2:0]      g;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_last;
  logic            out_ready;

  modport master (
    input  in_valid, in_data, g, out_ready,
    output in_ready, r, out_valid, out_data, out_src, out_last
  );

  modport slave (
    output in_valid, in_data, g, out_ready,
    input  in_ready, r, out_valid, out_data, out_src, out_last
  );
endinterface

// File: rtl/burst_requester.sv
// Client-side front end for a three-way request/grant arbiter.
// Each client owns a DEPTH-word FIFO. While a client holds data it raises r[i].
// When g[i] arrives, up to MAX_BURST words stream onto the shared output channel.
// r[i] then drops for at least one cycle so the arbiter can move on.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - burst_requester_if.master. It carries the client push ports, the
//          arbiter r/g pair and the shared output channel.
module burst_requester #(
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  burst_requester_if.master bus
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);

  localparam logic [CntW-1:0]   CountFull = CntW'(DEPTH);
  localparam logic [CntW-1:0]   CountOne  = CntW'(1);
  localparam logic [BurstW-1:0] BurstMax  = BurstW'(MAX_BURST);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StCool
  } state_e;

  // Per-client state
  state_e            state_q  [3];
  state_e            state_d  [3];
  logic [BurstW-1:0] burst_q  [3];
  logic [BurstW-1:0] burst_d  [3];
  logic [CntW-1:0]   count_q  [3];
  logic [CntW-1:0]   count_d  [3];
  logic [PtrW-1:0]   wr_ptr_q [3];
  logic [PtrW-1:0]   rd_ptr_q [3];
  logic [DW-1:0]     mem_q    [3][DEPTH];

  logic [2:0]        not_full;
  logic [2:0]        push;
  logic [2:0]        serve;    // lowest set bit of g
  logic [2:0]        active;   // served client is requesting and has data
  logic [2:0]        closing;  // a transfer now would end the burst
  logic [2:0]        pop;
  logic [2:0]        req;

  // FIFO space and pushes. Space comes from the registered count only, so a
  // pop does not free room for a push in the same cycle.
  always_comb begin
    not_full = '0;
    push     = '0;
    for (int i = 0; i < 3; i++) begin
      not_full[i] = (count_q[i] != CountFull);
      push[i]     = bus.in_valid[i] & not_full[i];
    end
  end

  // Only the lowest grant bit is honoured. Any extra bits from a misbehaving
  // arbiter are ignored.
  always_comb begin
    serve    = '0;
    serve[0] = bus.g[0];
    serve[1] = bus.g[1] & ~bus.g[0];
    serve[2] = bus.g[2] & ~bus.g[1] & ~bus.g[0];
  end

  // A grant reaching a client in IDLE or COOL is the arbiter's release tail.
  // It moves nothing.
  always_comb begin
    active  = '0;
    closing = '0;
    pop     = '0;
    for (int i = 0; i < 3; i++) begin
      active[i]  = serve[i] & (state_q[i] == StReq) & (count_q[i] != '0);
      closing[i] = ((burst_q[i] + BurstW'(1)) == BurstMax) |
                   ((count_q[i] == CountOne) & ~push[i]);
      pop[i]     = active[i] & bus.out_ready;
    end
  end

  // Shared output channel. It reads zero when nothing is being offered.
  always_comb begin
    bus.out_data = '0;
    bus.out_src  = '0;
    for (int i = 0; i < 3; i++) begin
      if (active[i]) begin
        bus.out_data = mem_q[i][rd_ptr_q[i]];
        bus.out_src  = 2'(i);
      end
    end
    bus.out_valid = |active;
    bus.out_last  = |(active & closing);
  end

  // Occupancy update
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      count_d[i] = count_q[i];
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CntW'(1);
        2'b01:   count_d[i] = count_q[i] - CntW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // Per-client request FSM.
  // COOL waits for the grant to fall, which guarantees the arbiter sees r[i]
  // low before this client asks again.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      burst_d[i] = burst_q[i];
      case (state_q[i])
        StIdle: begin
          if (count_q[i] != '0) begin
            state_d[i] = StReq;
          end
        end
        StReq: begin
          if (pop[i]) begin
            if (closing[i]) begin
              state_d[i] = StCool;
              burst_d[i] = '0;
            end else begin
              burst_d[i] = burst_q[i] + BurstW'(1);
            end
          end
        end
        StCool: begin
          if (!bus.g[i]) begin
            state_d[i] = StIdle;
          end
        end
        default: begin
          state_d[i] = StIdle;
          burst_d[i] = '0;
        end
      endcase
    end
  end

  // r is decoded straight from the state flops, so it is glitch-free and
  // effectively registered.
  always_comb begin
    req = '0;
    for (int i = 0; i < 3; i++) begin
      req[i] = (state_q[i] == StReq);
    end
  end

  assign bus.r        = req;
  assign bus.in_ready = not_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i]  <= StIdle;
        burst_q[i]  <= '0;
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        burst_q[i] <= burst_d[i];
        count_q[i] <= count_d[i];
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        end
      end
    end
  end

  // Storage is not reset. Output data is gated by active, so stale words never
  // become visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= bus.in_data[i*DW +: DW];
      end
    end
  end

endmodule
